// File: rtl/bits2bytes_if.sv
// Handshake bundle for bits2bytes_stream: bit beats in, packed byte words out.
// The slave modport is the packer; the master modport is its environment.
`timescale 1ns/1ps
interface bits2bytes_if #(
    parameter int N_BYTES = 4,
    parameter int IN_W    = 8
);
    logic [IN_W-1:0]              bits_i;
    logic                         valid_i;
    logic                         last_i;
    logic                         ready_o;
    logic [N_BYTES-1:0][7:0]      bytes_o;
    logic [$clog2(N_BYTES+1)-1:0] nbytes_o;
    logic                         last_o;
    logic                         valid_o;
    logic                         ready_i;

    modport slave (
        input  bits_i, valid_i, last_i, ready_i,
        output ready_o, bytes_o, nbytes_o, last_o, valid_o
    );

    modport master (
        output bits_i, valid_i, last_i, ready_i,
        input  ready_o, bytes_o, nbytes_o, last_o, valid_o
    );
endinterface

// File: rtl/bits2bytes_stream.sv
// Packs an LSB-first bit stream into N_BYTES-byte words (stream bit k -> byte k/8, bit k%8).
// Define BITS2BYTES_PIPE_EN to accept a new beat in the cycle a word is handed off.
`timescale 1ns/1ps
module bits2bytes_stream #(
    parameter int N_BYTES = 4,
    parameter int IN_W    = 8
) (
    input logic         clk_i,
    input logic         rst_ni,
    bits2bytes_if.slave bus
);
    localparam int W     = N_BYTES * 8;
    localparam int BEATS = W / IN_W;
    localparam int PW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NW    = $clog2(N_BYTES + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(BEATS - 1);

    typedef enum logic {FILL, OUT} state_t;

    state_t        state, state_n;
    logic [PW-1:0] ptr;
    logic [W-1:0]  acc;
    logic [NW-1:0] nbytes;
    logic          last_q;
    logic          accept, done, wrap;

    function automatic logic [NW-1:0] fill_bytes(input logic [PW-1:0] p);
        int unsigned nbits;
        nbits = (32'(p) + 32'd1) * 32'(IN_W);
        return NW'((nbits + 32'd7) / 32'd8);
    endfunction

    assign accept = bus.valid_i && bus.ready_o;
    assign done   = (state == OUT) && bus.ready_i;
    // ptr is 0 whenever we sit in OUT, so this also covers a beat taken during hand-off
    assign wrap   = (ptr == LAST_PTR) || bus.last_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= FILL;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            FILL: if (accept && wrap) state_n = OUT;
            OUT:  if (done) state_n = (accept && wrap) ? OUT : FILL;
            default: state_n = FILL;
        endcase
    end

    always_comb begin
        bus.ready_o  = 1'b0;
        bus.valid_o  = (state == OUT);
        bus.bytes_o  = (state == OUT) ? acc : '0;
        bus.nbytes_o = (state == OUT) ? nbytes : '0;
        bus.last_o   = (state == OUT) && last_q;
        if (rst_ni) begin
            unique case (state)
                FILL: bus.ready_o = 1'b1;
`ifdef BITS2BYTES_PIPE_EN
                OUT:  bus.ready_o = bus.ready_i;
`else
                OUT:  bus.ready_o = 1'b0;
`endif
                default: bus.ready_o = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr    <= '0;
            acc    <= '0;
            nbytes <= '0;
            last_q <= 1'b0;
        end else begin
            if (done) begin
                acc <= '0;
                ptr <= '0;
            end
            if (accept) begin
                acc[ptr*IN_W +: IN_W] <= bus.bits_i;
                ptr <= wrap ? '0 : ptr + 1'b1;
                if (wrap) begin
                    nbytes <= fill_bytes(ptr);
                    last_q <= bus.last_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_bits2bytes_stream.sv
// Randomised and directed bench for bits2bytes_stream against a stream-level model.
`timescale 1ns/1ps
module tb_bits2bytes_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef BITS2BYTES_PIPE_EN
    localparam int PERIOD = 4;
`else
    localparam int PERIOD = 5;
`endif

    bits2bytes_if #(.N_BYTES(4), .IN_W(8)) b ();
    bits2bytes_if #(.N_BYTES(1), .IN_W(1)) s ();

    bits2bytes_stream #(.N_BYTES(4), .IN_W(8)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(b)
    );
    bits2bytes_stream #(.N_BYTES(1), .IN_W(1)) u_bit (
        .clk_i(clk), .rst_ni(rst_n), .bus(s)
    );

    typedef struct {
        logic [31:0] w;
        int          nb;
        bit          last;
    } word_t;

    word_t expq[$];

    // Stream-level model: chop the message bits into 32-bit words
    function automatic void model_msg(input logic [7:0] beats[$]);
        int nbits;
        int cnt;
        word_t e;
        nbits = beats.size() * 8;
        for (int st = 0; st < nbits; st += 32) begin
            cnt = nbits - st;
            if (cnt > 32) cnt = 32;
            e.w = '0;
            for (int k = 0; k < cnt; k++) e.w[k] = beats[(st+k)/8][(st+k)%8];
            e.nb = (cnt + 7) / 8;
            e.last = (st + 32 >= nbits);
            expq.push_back(e);
        end
    endfunction

    task automatic send_beat(input logic [7:0] d, input bit l);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        b.bits_i = d;
        b.last_i = l;
        b.valid_i = 1'b1;
        while (!ok && n < 300) begin
            #1;
            ok = b.ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL send_beat: not accepted, ready_o=%b want 1", b.ready_o);
        end
    endtask

    task automatic send_bit(input logic d, input bit l);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        s.bits_i = d;
        s.last_i = l;
        s.valid_i = 1'b1;
        while (!ok && n < 300) begin
            #1;
            ok = s.ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL send_bit: not accepted, ready_o=%b want 1", s.ready_o);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (b.valid_o !== 1'b0 || b.last_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b last=%b want 0 0", b.valid_o, b.last_o);
        end
        checks++;
        if (b.bytes_o !== 32'h0 || b.nbytes_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_data: bytes=%h nb=%0d want 0 0", b.bytes_o, b.nbytes_o);
        end
        checks++;
        if (s.valid_o !== 1'b0 || s.bytes_o !== 8'h0) begin
            errors++;
            $display("FAIL reset_bit: valid=%b bytes=%h want 0 00", s.valid_o, s.bytes_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (b.ready_o !== 1'b1 || b.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: ready=%b valid=%b want 1 0", b.ready_o, b.valid_o);
        end
    endtask

    task automatic test_full_word();
        b.ready_i = 1'b1;
        send_beat(8'hEF, 1'b0);
        send_beat(8'hCD, 1'b0);
        send_beat(8'hAB, 1'b0);
        send_beat(8'h89, 1'b1);
        b.valid_i = 1'b0;
        b.last_i = 1'b0;
        checks++;
        if (b.valid_o !== 1'b1 || b.bytes_o !== 32'h89ABCDEF) begin
            errors++;
            $display("FAIL full_word: valid=%b bytes=%h want 1 89abcdef", b.valid_o, b.bytes_o);
        end
        checks++;
        if (b.nbytes_o !== 3'd4 || b.last_o !== 1'b1) begin
            errors++;
            $display("FAIL full_meta: nb=%0d last=%b want 4 1", b.nbytes_o, b.last_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (b.valid_o !== 1'b0 || b.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_drain: valid=%b ready=%b want 0 1", b.valid_o, b.ready_o);
        end
    endtask

    task automatic test_partial();
        b.ready_i = 1'b1;
        send_beat(8'h12, 1'b0);
        send_beat(8'h34, 1'b1);
        b.valid_i = 1'b0;
        checks++;
        if (b.bytes_o !== 32'h00003412 || b.nbytes_o !== 3'd2 || b.last_o !== 1'b1) begin
            errors++;
            $display("FAIL partial: bytes=%h nb=%0d last=%b want 00003412 2 1",
                     b.bytes_o, b.nbytes_o, b.last_o);
        end
        @(posedge clk);
        #1;
        send_beat(8'h55, 1'b1);
        b.valid_i = 1'b0;
        checks++;
        if (b.bytes_o !== 32'h00000055 || b.nbytes_o !== 3'd1 || b.last_o !== 1'b1) begin
            errors++;
            $display("FAIL single_beat: bytes=%h nb=%0d last=%b want 00000055 1 1",
                     b.bytes_o, b.nbytes_o, b.last_o);
        end
        @(posedge clk);
        #1;
        b.last_i = 1'b0;
    endtask

    task automatic test_backpressure();
        b.ready_i = 1'b0;
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b0);
        send_beat(8'h03, 1'b0);
        send_beat(8'h04, 1'b0);
        b.valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (b.valid_o !== 1'b1 || b.bytes_o !== 32'h04030201 || b.ready_o !== 1'b0
                || b.last_o !== 1'b0 || b.nbytes_o !== 3'd4) begin
                errors++;
                $display("FAIL stall_%0d: valid=%b bytes=%h ready=%b last=%b nb=%0d want 1 04030201 0 0 4",
                         i, b.valid_o, b.bytes_o, b.ready_o, b.last_o, b.nbytes_o);
            end
            @(posedge clk);
            #1;
        end
        b.ready_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (b.valid_o !== 1'b0 || b.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: valid=%b ready=%b want 0 1", b.valid_o, b.ready_o);
        end
    endtask

    task automatic test_bit_serial();
        logic seq [8];
        logic [7:0] r;
        logic [7:0] want;
        seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        s.ready_i = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(seq[i], 1'b0);
        s.valid_i = 1'b0;
        checks++;
        if (s.valid_o !== 1'b1 || s.bytes_o !== 8'h8D || s.nbytes_o !== 1'b1 || s.last_o !== 1'b0) begin
            errors++;
            $display("FAIL bit_serial: valid=%b bytes=%h nb=%0d last=%b want 1 8d 1 0",
                     s.valid_o, s.bytes_o, s.nbytes_o, s.last_o);
        end
        @(posedge clk);
        #1;
        r = 8'($urandom);
        want = '0;
        for (int i = 0; i < 6; i++) begin
            want[i] = r[i];
            send_bit(r[i], i == 5);
        end
        s.valid_i = 1'b0;
        s.last_i = 1'b0;
        checks++;
        if (s.bytes_o !== want || s.nbytes_o !== 1'b1 || s.last_o !== 1'b1) begin
            errors++;
            $display("FAIL bit_partial: bytes=%h nb=%0d last=%b want %h 1 1",
                     s.bytes_o, s.nbytes_o, s.last_o, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        b.ready_i = 1'b1;
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b0);
        b.valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (b.valid_o !== 1'b0 || b.bytes_o !== 32'h0 || b.nbytes_o !== 3'd0 || b.last_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b bytes=%h nb=%0d last=%b want 0 0 0 0",
                     b.valid_o, b.bytes_o, b.nbytes_o, b.last_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b0);
        send_beat(8'h44, 1'b0);
        b.valid_i = 1'b0;
        checks++;
        if (b.bytes_o !== 32'h44332211 || b.nbytes_o !== 3'd4 || b.last_o !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: bytes=%h nb=%0d last=%b want 44332211 4 0",
                     b.bytes_o, b.nbytes_o, b.last_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int lens [6];
        int total;
        total = 0;
        expq.delete();
        foreach (lens[m]) begin
            lens[m] = $urandom_range(1, 9);
            total += (lens[m] + 3) / 4;
        end
        fork
            begin
                logic [7:0] msg[$];
                foreach (lens[m]) begin
                    msg.delete();
                    for (int i = 0; i < lens[m]; i++) msg.push_back(8'($urandom));
                    model_msg(msg);
                    for (int i = 0; i < lens[m]; i++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            b.valid_i = 1'b0;
                            @(posedge clk);
                            #1;
                        end
                        send_beat(msg[i], i == lens[m] - 1);
                    end
                end
                b.valid_i = 1'b0;
                b.last_i = 1'b0;
            end
            begin
                int got;
                int n;
                word_t e;
                got = 0;
                n = 0;
                while (got < total && n < 3000) begin
                    b.ready_i = 1'($urandom_range(0, 1));
                    #1;
                    if (b.valid_o && b.ready_i) begin
                        got++;
                        checks++;
                        if (expq.size() == 0) begin
                            errors++;
                            $display("FAIL rand_extra: bytes=%h want no word", b.bytes_o);
                        end else begin
                            e = expq.pop_front();
                            if (b.bytes_o !== e.w || b.nbytes_o !== 3'(e.nb) || b.last_o !== e.last) begin
                                errors++;
                                $display("FAIL rand_word_%0d: bytes=%h nb=%0d last=%b want %h %0d %b",
                                         got, b.bytes_o, b.nbytes_o, b.last_o, e.w, e.nb, e.last);
                            end
                        end
                    end
                    @(posedge clk);
                    #1;
                    n++;
                end
                checks++;
                if (got != total) begin
                    errors++;
                    $display("FAIL rand_count: got %0d words want %0d", got, total);
                end
                b.ready_i = 1'b1;
            end
        join
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL rand_left: %0d expected words unseen want 0", expq.size());
        end
        expq.delete();
    endtask

    task automatic test_back_to_back();
        int t [3];
        b.ready_i = 1'b1;
        expq.delete();
        fork
            begin
                logic [7:0] msg[$];
                for (int i = 0; i < 12; i++) msg.push_back(8'($urandom));
                model_msg(msg);
                for (int i = 0; i < 12; i++) send_beat(msg[i], i == 11);
                b.valid_i = 1'b0;
                b.last_i = 1'b0;
            end
            begin
                int got;
                int n;
                word_t e;
                got = 0;
                n = 0;
                #1;
                while (got < 3 && n < 200) begin
                    if (b.valid_o && expq.size() > 0) begin
                        t[got] = cyc;
                        e = expq.pop_front();
                        got++;
                        checks++;
                        if (b.bytes_o !== e.w || b.last_o !== e.last) begin
                            errors++;
                            $display("FAIL b2b_word_%0d: bytes=%h last=%b want %h %b",
                                     got, b.bytes_o, b.last_o, e.w, e.last);
                        end
                    end
                    @(posedge clk);
                    #2;
                    n++;
                end
                checks++;
                if (got != 3) begin
                    errors++;
                    $display("FAIL b2b_count: got %0d words want 3", got);
                end
                #8;
            end
        join
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (t[i] - t[i-1] != PERIOD) begin
                errors++;
                $display("FAIL b2b_period_%0d: %0d cycles want %0d", i, t[i] - t[i-1], PERIOD);
            end
        end
        expq.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b.bits_i = '0;
        b.valid_i = 1'b0;
        b.last_i = 1'b0;
        b.ready_i = 1'b1;
        s.bits_i = '0;
        s.valid_i = 1'b0;
        s.last_i = 1'b0;
        s.ready_i = 1'b1;
        test_reset();
        test_full_word();
        test_partial();
        test_backpressure();
        test_bit_serial();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
